// File: rtl/cpu_pkg.sv
// Shared pipeline definitions: datapath/register widths, register-index type, reset values.
package cpu_pkg;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 3;

    typedef logic [ADDR_W-1:0] reg_idx_t;
    typedef logic [DATA_W-1:0] data_t;

    localparam reg_idx_t REG_RST  = '0;
    localparam data_t    DATA_RST = '0;

endpackage

// File: rtl/operand_forward.sv
// Read-after-write bypass for one ID-stage operand: WB value wins over register file data.
module operand_forward #(
    parameter int DATA_W = cpu_pkg::DATA_W,
    parameter int ADDR_W = cpu_pkg::ADDR_W
) (
    input  logic              wb_write,
    input  logic [ADDR_W-1:0] wb_reg,
    input  logic [DATA_W-1:0] wb_data,
    input  logic [ADDR_W-1:0] read_reg,
    input  logic [DATA_W-1:0] read_data,
    output logic [DATA_W-1:0] fwd_data,
    output logic              fwd_hit
);

    always_comb begin
        fwd_hit  = wb_write && (wb_reg == read_reg);
        fwd_data = fwd_hit ? wb_data : read_data;
    end

endmodule

// File: rtl/writeback_forward_unit.sv
// Write-back stage: EX->WB register, register file write port, operand forwarding
// and a saturating count of retired register writes.
module writeback_forward_unit #(
    parameter int DATA_W = cpu_pkg::DATA_W,
    parameter int ADDR_W = cpu_pkg::ADDR_W,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ex_valid,
    input  logic              ex_regwrite,
    input  logic [ADDR_W-1:0] ex_write_reg,
    input  logic [DATA_W-1:0] ex_result,
    input  logic              stall,
    input  logic              flush,
    input  logic [ADDR_W-1:0] id_read_reg_1,
    input  logic [ADDR_W-1:0] id_read_reg_2,
    input  logic [DATA_W-1:0] rf_read_data_1,
    input  logic [DATA_W-1:0] rf_read_data_2,
    output logic [ADDR_W-1:0] rf_write_reg,
    output logic [DATA_W-1:0] rf_write_data,
    output logic              rf_regwrite,
    output logic [DATA_W-1:0] fwd_data_1,
    output logic [DATA_W-1:0] fwd_data_2,
    output logic              fwd_hit_1,
    output logic              fwd_hit_2,
    output logic [CNT_W-1:0]  wb_count
);

    logic              wb_valid;
    logic              wb_regwrite;
    logic [ADDR_W-1:0] wb_reg;
    logic [DATA_W-1:0] wb_data;
    logic [CNT_W-1:0]  count_q;

    // Flush only kills wb_valid; the stale payload is harmless once invalid.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wb_valid    <= 1'b0;
            wb_regwrite <= 1'b0;
            wb_reg      <= ADDR_W'(cpu_pkg::REG_RST);
            wb_data     <= DATA_W'(cpu_pkg::DATA_RST);
        end else if (flush) begin
            wb_valid    <= 1'b0;
        end else if (!stall) begin
            wb_valid    <= ex_valid;
            wb_regwrite <= ex_regwrite;
            wb_reg      <= ex_write_reg;
            wb_data     <= ex_result;
        end
    end

    // A stalled write is repeated on the port but retired only once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else if (rf_regwrite && !stall && (count_q != '1)) begin
            count_q <= count_q + 1'b1;
        end
    end

    always_comb begin
        rf_regwrite   = wb_valid && wb_regwrite;
        rf_write_reg  = wb_reg;
        rf_write_data = wb_data;
        wb_count      = count_q;
    end

    operand_forward #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W)
    ) u_fwd_1 (
        .wb_write (rf_regwrite),
        .wb_reg   (wb_reg),
        .wb_data  (wb_data),
        .read_reg (id_read_reg_1),
        .read_data(rf_read_data_1),
        .fwd_data (fwd_data_1),
        .fwd_hit  (fwd_hit_1)
    );

    operand_forward #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W)
    ) u_fwd_2 (
        .wb_write (rf_regwrite),
        .wb_reg   (wb_reg),
        .wb_data  (wb_data),
        .read_reg (id_read_reg_2),
        .read_data(rf_read_data_2),
        .fwd_data (fwd_data_2),
        .fwd_hit  (fwd_hit_2)
    );

endmodule

// File: tb/tb_writeback_forward_unit.sv
// Directed plus randomized bench for writeback_forward_unit against a behavioural model.
module tb_writeback_forward_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic       ex_valid, ex_regwrite, stall, flush;
    logic [2:0] ex_write_reg, id_read_reg_1, id_read_reg_2;
    logic [7:0] ex_result, rf_read_data_1, rf_read_data_2;
    logic [2:0] rf_write_reg;
    logic [7:0] rf_write_data, fwd_data_1, fwd_data_2, wb_count;
    logic       rf_regwrite, fwd_hit_1, fwd_hit_2;

    int checks   = 0;
    int failures = 0;

    // Behavioural model: the instruction pending write-back and a retired-write tally.
    bit       m_pending;   // a valid register write is sitting in WB
    bit       m_live;      // WB holds a valid instruction (write or not)
    bit [2:0] m_reg;
    bit [7:0] m_data;
    int       m_retired;

    writeback_forward_unit #(.DATA_W(8), .ADDR_W(3), .CNT_W(8)) dut (
        .clk(clk), .reset(reset),
        .ex_valid(ex_valid), .ex_regwrite(ex_regwrite),
        .ex_write_reg(ex_write_reg), .ex_result(ex_result),
        .stall(stall), .flush(flush),
        .id_read_reg_1(id_read_reg_1), .id_read_reg_2(id_read_reg_2),
        .rf_read_data_1(rf_read_data_1), .rf_read_data_2(rf_read_data_2),
        .rf_write_reg(rf_write_reg), .rf_write_data(rf_write_data),
        .rf_regwrite(rf_regwrite),
        .fwd_data_1(fwd_data_1), .fwd_data_2(fwd_data_2),
        .fwd_hit_1(fwd_hit_1), .fwd_hit_2(fwd_hit_2),
        .wb_count(wb_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        bit       h1, h2;
        h1 = m_pending && (m_reg == id_read_reg_1);
        h2 = m_pending && (m_reg == id_read_reg_2);
        chk({tag, ".regwrite"}, {31'd0, rf_regwrite}, {31'd0, m_pending});
        if (m_pending) begin
            chk({tag, ".wreg"},  {29'd0, rf_write_reg},  {29'd0, m_reg});
            chk({tag, ".wdata"}, {24'd0, rf_write_data}, {24'd0, m_data});
        end
        chk({tag, ".hit1"}, {31'd0, fwd_hit_1}, {31'd0, h1});
        chk({tag, ".hit2"}, {31'd0, fwd_hit_2}, {31'd0, h2});
        chk({tag, ".fwd1"}, {24'd0, fwd_data_1}, {24'd0, h1 ? m_data : rf_read_data_1});
        chk({tag, ".fwd2"}, {24'd0, fwd_data_2}, {24'd0, h2 ? m_data : rf_read_data_2});
        chk({tag, ".count"}, {24'd0, wb_count}, (m_retired > 255) ? 32'd255 : 32'(m_retired));
    endtask

    // One clock edge: advance the model from the pre-edge inputs, then sample #1 after.
    task automatic tick();
        bit       n_pending, n_live;
        bit [2:0] n_reg;
        bit [7:0] n_data;
        if (m_pending && !stall) m_retired++;
        n_pending = m_pending; n_live = m_live; n_reg = m_reg; n_data = m_data;
        if (flush) begin
            n_pending = 1'b0; n_live = 1'b0;
        end else if (!stall) begin
            n_live = ex_valid;
            n_pending = ex_valid && ex_regwrite;
            n_reg = ex_write_reg; n_data = ex_result;
        end
        @(posedge clk);
        m_pending = n_pending; m_live = n_live; m_reg = n_reg; m_data = n_data;
        #1;
    endtask

    task automatic model_reset();
        m_pending = 1'b0; m_live = 1'b0; m_reg = '0; m_data = '0; m_retired = 0;
    endtask

    task automatic drive_ex(input bit v, input bit w, input bit [2:0] r, input bit [7:0] d);
        ex_valid = v; ex_regwrite = w; ex_write_reg = r; ex_result = d;
    endtask

    initial begin
        reset = 1'b0; stall = 1'b0; flush = 1'b0;
        drive_ex(1'b1, 1'b1, 3'd6, 8'h5A);
        id_read_reg_1 = 3'd0; id_read_reg_2 = 3'd0;
        rf_read_data_1 = 8'h12; rf_read_data_2 = 8'h34;
        model_reset();

        // Reset held with active EX inputs across edges
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        chk("reset.wreg0",  {29'd0, rf_write_reg},  32'd0);
        chk("reset.wdata0", {24'd0, rf_write_data}, 32'd0);

        // Release between edges, EX idle: nothing captured yet
        drive_ex(1'b0, 1'b0, 3'd0, 8'h00);
        #2 reset = 1'b1;
        #1 check_all("release");

        // Basic write-back
        drive_ex(1'b1, 1'b1, 3'd5, 8'hA7);
        tick();
        check_all("basic");
        chk("basic.wreg_const",  {29'd0, rf_write_reg},  32'd5);
        chk("basic.wdata_const", {24'd0, rf_write_data}, 32'hA7);
        drive_ex(1'b0, 1'b0, 3'd0, 8'h00);
        tick();
        chk("basic.count_const", {24'd0, wb_count}, 32'd1);

        // Forwarding both operands from the same register
        drive_ex(1'b1, 1'b1, 3'd3, 8'h3C);
        tick();
        id_read_reg_1 = 3'd3; id_read_reg_2 = 3'd3;
        rf_read_data_1 = 8'h00; rf_read_data_2 = 8'h00;
        #1 check_all("fwd_both");
        chk("fwd_both.d1_const", {24'd0, fwd_data_1}, 32'h3C);
        id_read_reg_2 = 3'd4; rf_read_data_2 = 8'h99;
        #1 check_all("fwd_one");
        chk("fwd_one.d2_const", {24'd0, fwd_data_2}, 32'h99);

        // Non-writing and invalid instructions to r3
        drive_ex(1'b1, 1'b0, 3'd3, 8'hEE);
        id_read_reg_1 = 3'd3; id_read_reg_2 = 3'd3;
        tick();
        check_all("nowrite");
        drive_ex(1'b0, 1'b1, 3'd3, 8'hEE);
        tick();
        check_all("invalid");

        // Register 0 is forwardable
        drive_ex(1'b1, 1'b1, 3'd0, 8'h77);
        id_read_reg_1 = 3'd0;
        tick();
        check_all("r0");
        chk("r0.hit_const", {31'd0, fwd_hit_1}, 32'd1);

        // Stall three cycles: write repeats, counted once
        drive_ex(1'b1, 1'b1, 3'd2, 8'h11);
        tick();
        stall = 1'b1;
        drive_ex(1'b1, 1'b1, 3'd7, 8'hFF);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_all("stall");
        end
        flush = 1'b1;
        tick();
        check_all("flush_stall");
        chk("flush_stall.we_const", {31'd0, rf_regwrite}, 32'd0);
        stall = 1'b0; flush = 1'b0;

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            drive_ex(1'($urandom), 1'($urandom), 3'($urandom), 8'($urandom));
            stall = ($urandom_range(0, 3) == 0);
            flush = ($urandom_range(0, 7) == 0);
            id_read_reg_1 = 3'($urandom); id_read_reg_2 = 3'($urandom);
            rf_read_data_1 = 8'($urandom); rf_read_data_2 = 8'($urandom);
            tick();
            check_all("rand");
            id_read_reg_1 = 3'($urandom); rf_read_data_2 = 8'($urandom);
            #1 check_all("rand_comb");
        end

        // Saturation
        stall = 1'b0; flush = 1'b0;
        for (int i = 0; i < 260; i++) begin
            drive_ex(1'b1, 1'b1, 3'($urandom), 8'($urandom));
            tick();
        end
        check_all("sat");
        chk("sat.count_const", {24'd0, wb_count}, 32'd255);

        // Asynchronous reset between edges with a write pending
        #2 reset = 1'b0;
        #1 model_reset();
        check_all("async_reset");
        chk("async_reset.we_const", {31'd0, rf_regwrite}, 32'd0);
        chk("async_reset.cnt_const", {24'd0, wb_count}, 32'd0);
        reset = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/writeback_forward_unit.md
# writeback_forward_unit

Write-back stage of the 4-stage pipeline. Holds one EX→WB pipeline register and drives the register file write port (write_reg / write_data / regwrite). Resolves read-after-write hazards for the two ID-stage read operands by forwarding the in-flight write-back value over the register-file read data. Keeps a saturating count of retired register writes for debug.

## Interface
- DATA_W, 8, register / datapath width
- ADDR_W, 3, register address width (2**ADDR_W registers)
- CNT_W, 8, retired-write counter width

- clk  in  1  pipeline clock, rising edge
- reset  in  1  asynchronous, active-low; one clock domain, clk
- ex_valid  in  1  EX stage holds a real instruction this cycle
- ex_regwrite  in  1  EX instruction writes a register
- ex_write_reg  in  ADDR_W  EX destination register
- ex_result  in  DATA_W  EX result to be written back
- stall  in  1  hold WB register contents
- flush  in  1  discard WB register contents (bubble)
- id_read_reg_1, id_read_reg_2  in  ADDR_W  ID-stage source register addresses
- rf_read_data_1, rf_read_data_2  in  DATA_W  register file read data for those addresses
- rf_write_reg  out  ADDR_W  register file write address
- rf_write_data  out  DATA_W  register file write data
- rf_regwrite  out  1  register file write enable
- fwd_data_1, fwd_data_2  out  DATA_W  resolved operand values for ID/EX
- fwd_hit_1, fwd_hit_2  out  1  operand n was taken from the WB register
- wb_count  out  CNT_W  number of retired register writes, saturating

## Operation
- WB register fields: wb_valid, wb_regwrite, wb_reg, wb_data.
- Each rising edge, in priority order:
  1. flush=1: wb_valid←0. Other fields are don't-care. Flush wins over stall.
  2. stall=1: all fields hold.
  3. Otherwise: wb_valid←ex_valid, wb_regwrite←ex_regwrite, wb_reg←ex_write_reg, wb_data←ex_result.
- Write port, combinational from the WB register:
  - rf_regwrite = wb_valid & wb_regwrite
  - rf_write_reg = wb_reg
  - rf_write_data = wb_data
- Repeated write while stalled: rf_regwrite stays high on every stalled cycle. This is idempotent on the register file and is intentional.
- Forwarding, for n = 1, 2:
  - fwd_hit_n = rf_regwrite & (wb_reg == id_read_reg_n)
  - fwd_data_n = fwd_hit_n ? wb_data : rf_read_data_n
- All registers, including r0, are writable and forwardable. There is no hard-wired zero register.
- Both operands may hit in the same cycle, e.g. both read the same register. Each is forwarded independently.
- wb_count increments by 1 on each rising edge where rf_regwrite=1 and stall=0 (one count per retired write). It holds at 2**CNT_W−1 and never wraps.

## Timing
- Reset (reset=0), asynchronous, all outputs take these values with no clock edge required:
  - wb_valid=0, wb_regwrite=0, wb_reg=0, wb_data=0, wb_count=0
  - hence rf_regwrite=0, rf_write_reg=0, rf_write_data=0, fwd_hit_n=0, fwd_data_n=rf_read_data_n
- Reset asserted mid-operation drops rf_regwrite in the same cycle. The pending write is lost.
- Latency:
  - EX inputs appear on the rf_* outputs 1 cycle after capture.
  - Forwarding outputs are combinational: 0-cycle path from id_read_reg_n and rf_read_data_n.
- Flush and stall take effect on the next rising edge. They have no combinational effect on outputs.
- wb_count updates on the edge that retires the write. It is visible one cycle after rf_regwrite was high.

## Structure
- Shared package `cpu_pkg`: DATA_W, ADDR_W, the register-index type, and the reset values. These are also used by the register file and the decode stage.
- One sub-module, `operand_forward`: the compare-and-mux for one operand, instantiated twice.
- The WB register and the counter live in the top level.

## Test plan
- Reset: hold reset=0 with ex_* active → rf_regwrite=0, wb_count=0, fwd_data_1 equals rf_read_data_1. Release reset → values stay until the first capture.
- Basic write-back: ex_valid=1, ex_regwrite=1, ex_write_reg=5, ex_result=8'hA7, one edge → rf_regwrite=1, rf_write_reg=5, rf_write_data=8'hA7, wb_count=1 after the next edge.
- Forwarding: with WB holding r3=8'h3C, drive id_read_reg_1=3, id_read_reg_2=3, rf_read_data=8'h00 → both fwd_data=8'h3C, both fwd_hit=1. Change id_read_reg_2=4 → fwd_data_2=rf_read_data_2, fwd_hit_2=0.
- Non-write and invalid: ex_regwrite=0 (or ex_valid=0) to r3 → rf_regwrite=0, no forwarding hit, wb_count unchanged.
- Stall/flush: capture r2=8'h11, stall 3 cycles → rf_regwrite stays 1, wb_count +1 total. Then assert flush and stall together → rf_regwrite=0 next cycle.
- Saturation and async reset: perform 260 consecutive writes → wb_count=255. Assert reset between edges while rf_regwrite=1 → rf_regwrite=0 and wb_count=0 immediately.
